// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Brief    : Shares a 128x4 asynchronous-read SRAM between a small CPU and a
//            host port.
//            RESTART holds the CPU in reset for RST_CYCLES cycles.
//            RUN gives the CPU bus ownership of the SRAM.
//            HOST keeps the CPU in reset and serves single-beat host
//            accesses, each acknowledged with a one-cycle pulse.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cpu_io_out[7:0]     - CPU bus: [7] addr strobe, [6:0] addr,
//                                  [5] write strobe (active low), [3:0] data
//            cpu_rst, cpu_rdata  - reset and read nibble to the CPU
//            host_halt/req/we/addr/wdata - host control and access request
//            host_ack, host_rdata - access-complete pulse, registered data
//            sram_addr/wdata/we, sram_rdata - SRAM macro interface
//            state[1:0]          - 0=RESTART, 1=RUN, 2=HOST
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_io_out,
    output logic       cpu_rst,
    output logic [3:0] cpu_rdata,
    input  logic       host_halt,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [6:0] host_addr,
    input  logic [3:0] host_wdata,
    output logic       host_ack,
    output logic [3:0] host_rdata,
    output logic [6:0] sram_addr,
    output logic [3:0] sram_wdata,
    output logic       sram_we,
    input  logic [3:0] sram_rdata,
    output logic [1:0] state
);

    localparam logic [1:0] C_ST_RESTART = 2'd0;
    localparam logic [1:0] C_ST_RUN     = 2'd1;
    localparam logic [1:0] C_ST_HOST    = 2'd2;

    localparam int              C_CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(RST_CYCLES - 1);

    logic [1:0]         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_cpu_rst;
    logic [6:0]         r_addr_q;
    logic               r_host_ack;
    logic [3:0]         r_host_rdata;

    logic [6:0]         w_sram_addr;
    logic [3:0]         w_sram_wdata;
    logic               w_sram_we;
    logic               w_host_access;
    logic               w_unused_bits;

    // Bit 4 of the CPU bus carries no meaning for this block.
    assign w_unused_bits = cpu_io_out[4];

    // SRAM steering. Outside an active CPU cycle or host access the SRAM
    // is parked on the last CPU address with writes disabled.
    always_comb begin
        w_sram_addr   = r_addr_q;
        w_sram_wdata  = 4'h0;
        w_sram_we     = 1'b0;
        w_host_access = 1'b0;
        case (r_state)
            C_ST_RUN: begin
                w_sram_wdata = cpu_io_out[3:0];
                if (cpu_io_out[7]) begin
                    w_sram_addr = cpu_io_out[6:0];
                end else begin
                    w_sram_we = ~cpu_io_out[5];
                end
            end
            C_ST_HOST: begin
                // The ack cycle is a forced idle so the host can retire or
                // replace its request; this spaces accesses two cycles apart.
                if (host_req && !r_host_ack) begin
                    w_host_access = 1'b1;
                    w_sram_addr   = host_addr;
                    w_sram_wdata  = host_wdata;
                    w_sram_we     = host_we;
                end
            end
            default: ;
        endcase
        if (rst) begin
            w_sram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= C_ST_RESTART;
            r_cnt        <= '0;
            r_cpu_rst    <= 1'b1;
            r_addr_q     <= 7'h00;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 4'h0;
        end else begin
            r_host_ack <= 1'b0;
            case (r_state)
                C_ST_RESTART: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_state   <= C_ST_RUN;
                        r_cpu_rst <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                C_ST_RUN: begin
                    if (cpu_io_out[7]) begin
                        r_addr_q <= cpu_io_out[6:0];
                    end
                    // Any CPU write this cycle completes through the
                    // combinational path before ownership moves to the host.
                    if (host_halt) begin
                        r_state   <= C_ST_HOST;
                        r_cpu_rst <= 1'b1;
                    end
                end
                C_ST_HOST: begin
                    if (w_host_access) begin
                        r_host_ack   <= 1'b1;
                        r_host_rdata <= sram_rdata;
                    end else if (!host_halt && !host_req && !r_host_ack) begin
                        // Leave only once nothing is in flight.
                        r_state   <= C_ST_RESTART;
                        r_cnt     <= '0;
                        r_addr_q  <= 7'h00;
                        r_cpu_rst <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= C_ST_RESTART;
                    r_cnt     <= '0;
                    r_cpu_rst <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_rst    = r_cpu_rst;
    assign cpu_rdata  = sram_rdata;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;
    assign sram_addr  = w_sram_addr;
    assign sram_wdata = w_sram_wdata;
    assign sram_we    = w_sram_we;
    assign state      = r_state;

endmodule
`default_nettype wire
